// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and memory stages.
// Data accesses win arbitration unless fetch has been passed over STARVE_MAX times in a row.
module mem_port_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_valid,
  output logic [DW-1:0] f_rdata,
  output logic          f_err,
  output logic          f_stall,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic          m_valid,
  output logic [DW-1:0] m_rdata,
  output logic          m_err,
  output logic          m_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, F_WAIT = 2'd1, M_WAIT = 2'd2} state_t;

  localparam logic [3:0] STREAK_CAP = 4'(STARVE_MAX);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_streak;
  logic [7:0]    r_wait;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_f_valid;
  logic [DW-1:0] r_f_rdata;
  logic          r_f_err;
  logic          r_m_valid;
  logic [DW-1:0] r_m_rdata;
  logic          r_m_err;
  logic          w_grant_m;
  logic          w_grant_f;
  logic          w_ack;
  logic          w_tmo;
  logic          w_done;

  function automatic logic [3:0] streak_inc(input logic [3:0] v);
    return (v >= STREAK_CAP) ? STREAK_CAP : v + 4'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_m)      w_next = M_WAIT;
        else if (w_grant_f) w_next = F_WAIT;
      end
      F_WAIT, M_WAIT: if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grant decisions are only taken in IDLE; ack and timeout are only honoured while waiting.
  always_comb begin
    w_grant_m = 1'b0;
    w_grant_f = 1'b0;
    w_ack     = 1'b0;
    w_tmo     = 1'b0;
    if (r_state == IDLE) begin
      w_grant_m = m_req && ((r_streak < STREAK_CAP) || !f_req);
      w_grant_f = f_req && !w_grant_m;
    end else begin
      w_ack = mem_ack;
      w_tmo = !mem_ack && (r_wait == WAIT_LAST);
    end
  end

  assign w_done = w_ack | w_tmo;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_streak    <= '0;
      r_wait      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_f_valid   <= 1'b0;
      r_f_rdata   <= '0;
      r_f_err     <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_rdata   <= '0;
      r_m_err     <= 1'b0;
    end else begin
      r_f_valid <= 1'b0;
      r_m_valid <= 1'b0;
      if (w_grant_m || w_grant_f) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_grant_m & m_we;
        r_mem_addr  <= w_grant_m ? m_addr : f_addr;
        r_mem_wdata <= w_grant_m ? m_wdata : '0;
        r_wait      <= '0;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
        if (r_state == F_WAIT) begin
          r_f_valid <= 1'b1;
          r_f_err   <= w_tmo;
          r_f_rdata <= w_ack ? mem_rdata : '0;
        end else begin
          r_m_valid <= 1'b1;
          r_m_err   <= w_tmo;
          r_m_rdata <= (w_ack && !r_mem_we) ? mem_rdata : '0;
        end
      end else if (r_state != IDLE) begin
        r_wait <= r_wait + 8'd1;
      end
      // The streak only counts data wins that actually held fetch back.
      if (r_state == IDLE) begin
        if (!f_req || w_grant_f) r_streak <= '0;
        else if (w_grant_m)      r_streak <= streak_inc(r_streak);
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign f_valid   = r_f_valid;
  assign f_rdata   = r_f_rdata;
  assign f_err     = r_f_err;
  assign m_valid   = r_m_valid;
  assign m_rdata   = r_m_rdata;
  assign m_err     = r_m_err;
  assign busy      = (r_state != IDLE);
  assign f_stall   = f_req & ~r_f_valid;
  assign m_stall   = m_req & ~r_m_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the two requesters and the shared memory.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SM = 4;
  localparam int TO = 32;

  logic          clock;
  logic          reset;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_valid;
  logic [DW-1:0] f_rdata;
  logic          f_err;
  logic          f_stall;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_valid;
  logic [DW-1:0] m_rdata;
  logic          m_err;
  logic          m_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // memory responder controls
  int          fix_lat  = -1;
  bit          resp_on  = 1'b1;
  bit          force_en = 1'b0;
  logic [63:0] force_val = '0;
  bit          seen = 1'b0;
  int          wcnt = 0;
  int          cur_lat = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_rdata(f_rdata), .f_err(f_err), .f_stall(f_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_valid(m_valid), .m_rdata(m_rdata),
    .m_err(m_err), .m_stall(m_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] data_of(input logic [63:0] a);
    return {a[31:0], a[63:32]} ^ 64'hA5A5_0000_5A5A_FFFF;
  endfunction

  // Advance one cycle and act as the memory: ack cur_lat cycles after mem_req first rises.
  task automatic cyc();
    @(posedge clock);
    #1;
    mem_ack = 1'b0;
    if (mem_req === 1'b1) begin
      if (!seen) begin
        seen    = 1'b1;
        wcnt    = 0;
        cur_lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 4));
      end
      if (resp_on && wcnt == cur_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = force_en ? force_val : data_of(mem_addr);
      end
      wcnt++;
    end else begin
      seen = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; f_req = 1'b0; m_req = 1'b0; m_we = 1'b0;
    f_addr = '0; m_addr = '0; m_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    cyc(); cyc();
    n_checks++;
    if ({mem_req, mem_we, f_valid, m_valid, f_err, m_err, busy} !== 7'b0) begin
      n_errors++; $display("FAIL reset_ctrl got %b want 0000000", {mem_req, mem_we, f_valid, m_valid, f_err, m_err, busy});
    end
    n_checks++;
    if (mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
      n_errors++; $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if (f_rdata !== 64'h0 || m_rdata !== 64'h0) begin
      n_errors++; $display("FAIL reset_rdata got f=%h m=%h want 0", f_rdata, m_rdata);
    end
    reset = 1'b0;
    cyc();
    n_checks++;
    if ({mem_req, busy, f_stall, m_stall} !== 4'b0) begin
      n_errors++; $display("FAIL reset_idle got %b want 0000", {mem_req, busy, f_stall, m_stall});
    end
  endtask

  task automatic test_fetch_basic();
    int stalls;
    int n;
    fix_lat = 3; force_en = 1'b1; force_val = 64'h30F2_0A00;
    f_addr = 64'h40; f_req = 1'b1;
    #1;
    stalls = int'(f_stall);
    cyc();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h40 || mem_we !== 1'b0) begin
      n_errors++; $display("FAIL fetch_issue got req=%b addr=%h we=%b want 1 40 0", mem_req, mem_addr, mem_we);
    end
    n = 1;
    while (f_valid !== 1'b1 && n < 20) begin
      stalls += int'(f_stall);
      cyc();
      n++;
    end
    n_checks++;
    if (f_valid !== 1'b1 || f_rdata !== 64'h30F2_0A00 || f_err !== 1'b0) begin
      n_errors++; $display("FAIL fetch_result got v=%b d=%h e=%b want 1 30f20a00 0", f_valid, f_rdata, f_err);
    end
    n_checks++;
    if (stalls != 5 || f_stall !== 1'b0) begin
      n_errors++; $display("FAIL fetch_stall got cycles=%0d stall_now=%b want 5 0", stalls, f_stall);
    end
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_errors++; $display("FAIL fetch_req_drop got %b want 0", mem_req);
    end
    f_req = 1'b0;
    cyc();
    n_checks++;
    if (f_valid !== 1'b0 || f_rdata !== 64'h30F2_0A00 || busy !== 1'b0) begin
      n_errors++; $display("FAIL fetch_pulse_len got v=%b d=%h busy=%b want 0 30f20a00 0", f_valid, f_rdata, busy);
    end
    fix_lat = -1; force_en = 1'b0;
  endtask

  task automatic test_priority();
    int n;
    fix_lat = 1;
    m_we = 1'b1; m_addr = 64'h100; m_wdata = 64'hDEAD; m_req = 1'b1;
    f_addr = 64'h200; f_req = 1'b1;
    cyc();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h100 || mem_wdata !== 64'hDEAD) begin
      n_errors++; $display("FAIL prio_data_first got req=%b we=%b addr=%h wd=%h want 1 1 100 dead", mem_req, mem_we, mem_addr, mem_wdata);
    end
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    n_checks++;
    if (m_valid !== 1'b1 || m_rdata !== 64'h0 || m_err !== 1'b0 || f_valid !== 1'b0) begin
      n_errors++; $display("FAIL prio_write_done got mv=%b rd=%h err=%b fv=%b want 1 0 0 0", m_valid, m_rdata, m_err, f_valid);
    end
    m_req = 1'b0; m_we = 1'b0;
    cyc();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h200 || mem_wdata !== 64'h0) begin
      n_errors++; $display("FAIL prio_fetch_next got req=%b we=%b addr=%h wd=%h want 1 0 200 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    n = 0;
    while (f_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    n_checks++;
    if (f_valid !== 1'b1 || f_rdata !== data_of(64'h200)) begin
      n_errors++; $display("FAIL prio_fetch_data got v=%b d=%h want 1 %h", f_valid, f_rdata, data_of(64'h200));
    end
    f_req = 1'b0;
    cyc();
    fix_lat = -1;
  endtask

  task automatic test_starvation();
    bit gl[10];
    int ng;
    bit prev;
    bit exp_f;
    int n;
    ng = 0; prev = 1'b0;
    f_addr = 64'h300; f_req = 1'b1;
    m_we = 1'b0; m_addr = 64'h1000; m_wdata = '0; m_req = 1'b1;
    for (int i = 0; i < 400 && ng < 10; i++) begin
      cyc();
      if (mem_req === 1'b1 && !prev) begin
        gl[ng] = (mem_addr === 64'h300);
        ng++;
      end
      prev = (mem_req === 1'b1);
      if (m_valid === 1'b1) m_addr = m_addr + 64'h8;
    end
    f_req = 1'b0; m_req = 1'b0;
    n_checks++;
    if (ng != 10) begin
      n_errors++; $display("FAIL starve_grants got %0d want 10", ng);
    end
    for (int i = 0; i < ng; i++) begin
      exp_f = (i == 4 || i == 9);
      n_checks++;
      if (gl[i] != exp_f) begin
        n_errors++; $display("FAIL starve_order grant %0d got fetch=%0d want %0d", i, gl[i], exp_f);
      end
    end
    n = 0;
    while (busy !== 1'b0 && n < 40) begin cyc(); n++; end
    cyc();
  endtask

  task automatic test_timeout();
    int hi;
    int n;
    resp_on = 1'b0;
    m_we = 1'b0; m_addr = 64'h500; m_req = 1'b1;
    cyc();
    hi = 0; n = 0;
    while (mem_req === 1'b1 && n < 100) begin hi++; cyc(); n++; end
    n_checks++;
    if (hi != TO) begin
      n_errors++; $display("FAIL timeout_len got %0d want %0d", hi, TO);
    end
    n_checks++;
    if (m_valid !== 1'b1 || m_err !== 1'b1 || m_rdata !== 64'h0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL timeout_abort got v=%b err=%b rd=%h busy=%b want 1 1 0 0", m_valid, m_err, m_rdata, busy);
    end
    m_req = 1'b0;
    cyc();
    n_checks++;
    if (m_valid !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL timeout_after got v=%b req=%b busy=%b want 0 0 0", m_valid, mem_req, busy);
    end
    resp_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    resp_on = 1'b0;
    m_we = 1'b0; m_addr = 64'h600; m_req = 1'b1;
    cyc(); cyc();
    n_checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_wait got req=%b busy=%b want 1 1", mem_req, busy);
    end
    reset = 1'b1; m_req = 1'b0;
    cyc();
    n_checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_abort got req=%b busy=%b v=%b want 0 0 0", mem_req, busy, m_valid);
    end
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (m_valid !== 1'b0 || f_valid !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL rstmid_late_ack cyc %0d got mv=%b fv=%b req=%b busy=%b want 0 0 0 0", i, m_valid, f_valid, mem_req, busy);
      end
    end
    resp_on = 1'b1;
  endtask

  task automatic test_idle_ack();
    f_req = 1'b0; m_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 64'hABCD;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if (f_valid !== 1'b0 || m_valid !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL idle_ack cyc %0d got fv=%b mv=%b req=%b busy=%b want 0 0 0 0", i, f_valid, m_valid, mem_req, busy);
      end
    end
  endtask

  task automatic test_random();
    bit          busy_m, exp_grant, exp_done, ack_now, g_port, cur_port;
    logic        g_we, cur_we;
    logic [63:0] g_addr, g_wdata, cur_addr, exp_rd;
    int          streak;
    busy_m = 1'b0; exp_grant = 1'b0; exp_done = 1'b0; g_port = 1'b0; cur_port = 1'b0;
    g_we = 1'b0; cur_we = 1'b0; g_addr = '0; g_wdata = '0; cur_addr = '0; streak = 0;
    f_req = 1'b0; m_req = 1'b0;
    for (int i = 0; i < 900; i++) begin
      cyc();
      if (exp_done) begin
        exp_rd = (cur_port && cur_we) ? 64'h0 : data_of(cur_addr);
        if (cur_port) begin
          n_checks++;
          if (m_valid !== 1'b1 || f_valid !== 1'b0 || m_rdata !== exp_rd || m_err !== 1'b0) begin
            n_errors++; $display("FAIL rand_m_done cyc %0d got mv=%b fv=%b rd=%h err=%b want 1 0 %h 0", i, m_valid, f_valid, m_rdata, m_err, exp_rd);
          end
        end else begin
          n_checks++;
          if (f_valid !== 1'b1 || m_valid !== 1'b0 || f_rdata !== exp_rd || f_err !== 1'b0) begin
            n_errors++; $display("FAIL rand_f_done cyc %0d got fv=%b mv=%b rd=%h err=%b want 1 0 %h 0", i, f_valid, m_valid, f_rdata, f_err, exp_rd);
          end
        end
        busy_m = 1'b0;
      end else begin
        n_checks++;
        if ({f_valid, m_valid} !== 2'b00) begin
          n_errors++; $display("FAIL rand_no_valid cyc %0d got fv=%b mv=%b want 0 0", i, f_valid, m_valid);
        end
      end
      if (exp_grant) begin
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== g_we || mem_addr !== g_addr || mem_wdata !== g_wdata) begin
          n_errors++; $display("FAIL rand_grant cyc %0d got req=%b we=%b addr=%h wd=%h want 1 %b %h %h", i, mem_req, mem_we, mem_addr, mem_wdata, g_we, g_addr, g_wdata);
        end
        busy_m = 1'b1; cur_port = g_port; cur_we = g_we; cur_addr = g_addr;
      end else begin
        n_checks++;
        if (mem_req !== busy_m) begin
          n_errors++; $display("FAIL rand_req_level cyc %0d got %b want %b", i, mem_req, busy_m);
        end
      end
      ack_now = busy_m && (mem_ack === 1'b1);
      if (f_req && f_valid === 1'b1) f_req = 1'b0;
      if (m_req && m_valid === 1'b1) m_req = 1'b0;
      if (!f_req && i < 600 && $urandom_range(0, 2) == 0) begin
        f_req = 1'b1; f_addr = {$urandom, $urandom} & ~64'h7;
      end
      if (!m_req && i < 600 && $urandom_range(0, 3) != 0) begin
        m_req = 1'b1; m_we = 1'($urandom_range(0, 1));
        m_addr = {$urandom, $urandom} & ~64'h7; m_wdata = {$urandom, $urandom};
      end
      #1;
      n_checks++;
      if (f_stall !== (f_req & ~f_valid) || m_stall !== (m_req & ~m_valid)) begin
        n_errors++; $display("FAIL rand_stall cyc %0d got f=%b m=%b want %b %b", i, f_stall, m_stall, f_req & ~f_valid, m_req & ~m_valid);
      end
      // fetch may be passed over at most SM consecutive times while it is waiting
      exp_done = ack_now;
      exp_grant = 1'b0;
      if (!busy_m) begin
        if (m_req && (streak < SM || !f_req)) begin
          exp_grant = 1'b1; g_port = 1'b1; g_we = m_we; g_addr = m_addr; g_wdata = m_wdata;
          streak = f_req ? ((streak + 1 > SM) ? SM : streak + 1) : 0;
        end else if (f_req) begin
          exp_grant = 1'b1; g_port = 1'b0; g_we = 1'b0; g_addr = f_addr; g_wdata = '0;
          streak = 0;
        end else begin
          streak = 0;
        end
      end
    end
    n_checks++;
    if (f_req || m_req || busy_m || busy !== 1'b0) begin
      n_errors++; $display("FAIL rand_drain got freq=%b mreq=%b model_busy=%b busy=%b want 0 0 0 0", f_req, m_req, busy_m, busy);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_priority();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_idle_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
